// File: rtl/wbm_arb_if.sv
// Shared master Wishbone bus bundle around the arbiter.
// slave  : arbiter view (it serves the CPU/DMA requesters and drives the slave side)
// master : requesters and downstream slave view (they drive the arbiter inputs)
interface wbm_arb_if #(
  parameter int unsigned NDMA = 2
);
  // CPU master port
  logic                cpu_cyc_i;
  logic                cpu_stb_i;
  logic                cpu_we_i;
  logic                cpu_ios_i;
  logic [1:0]          cpu_sel_i;
  logic [21:0]         cpu_adr_i;
  logic [15:0]         cpu_dat_i;
  logic                cpu_gnt_o;
  logic                cpu_ack_o;
  // DMA master ports, port k packed at its own slice
  logic [NDMA-1:0]     dma_cyc_i;
  logic [NDMA-1:0]     dma_stb_i;
  logic [NDMA-1:0]     dma_we_i;
  logic [2*NDMA-1:0]   dma_sel_i;
  logic [22*NDMA-1:0]  dma_adr_i;
  logic [16*NDMA-1:0]  dma_dat_i;
  logic [NDMA-1:0]     dma_gnt_o;
  logic [NDMA-1:0]     dma_ack_o;
  logic [NDMA-1:0]     dma_err_o;
  // Read data back to all masters
  logic [15:0]         mst_dat_o;
  // Slave-side bus
  logic                wbs_cyc_o;
  logic                wbs_stb_o;
  logic                wbs_we_o;
  logic                wbs_ios_o;
  logic [1:0]          wbs_sel_o;
  logic [21:0]         wbs_adr_o;
  logic [15:0]         wbs_dat_o;
  logic [15:0]         wbs_dat_i;
  logic                wbs_ack_i;

  modport slave (
    input  cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_ios_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    output cpu_gnt_o, cpu_ack_o,
    input  dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    output dma_gnt_o, dma_ack_o, dma_err_o,
    output mst_dat_o,
    output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ios_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    input  wbs_dat_i, wbs_ack_i
  );

  modport master (
    output cpu_cyc_i, cpu_stb_i, cpu_we_i, cpu_ios_i, cpu_sel_i, cpu_adr_i, cpu_dat_i,
    input  cpu_gnt_o, cpu_ack_o,
    output dma_cyc_i, dma_stb_i, dma_we_i, dma_sel_i, dma_adr_i, dma_dat_i,
    input  dma_gnt_o, dma_ack_o, dma_err_o,
    input  mst_dat_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ios_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
    output wbs_dat_i, wbs_ack_i
  );
endinterface

// File: rtl/wbm_arb.sv
// Master-bus arbiter: CPU plus NDMA DMA masters, fixed DMA priority
// (port 0 highest), optional CPU fairness after DMA tenures, one dead
// turnaround cycle between owners, and a DMA stall timeout abort.
module wbm_arb #(
  parameter int unsigned NDMA   = 2,
  parameter int unsigned TMO_W  = 6,
  parameter int unsigned CPU_FR = 1
) (
  input  logic     vm_clk_p,
  input  logic     vm_dclo,
  wbm_arb_if.slave bus
);

  localparam int unsigned IDX_W = (NDMA > 1) ? $clog2(NDMA) : 1;
  // Error fires in the stalled cycle whose increment would reach all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

  state_t             state_q, state_d;
  logic               own_cpu_q, own_cpu_d;
  logic [IDX_W-1:0]   own_idx_q, own_idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               fair_q, fair_d;
  logic               blk_q, blk_d;

  logic               win_dma;
  logic [IDX_W-1:0]   win_idx;
  logic               cpu_win;
  logic               granted;
  logic               dma_own;
  logic               tmo_hit;
  logic               stb_eff;
  logic               ack;

  logic               o_cyc, o_stb, o_we, o_ios;
  logic [1:0]         o_sel;
  logic [21:0]        o_adr;
  logic [15:0]        o_dat;

  // Fixed-priority pick among DMA requests, lowest index wins
  always_comb begin
    win_dma = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < NDMA; k++) begin
      if (bus.dma_cyc_i[k] && !win_dma) begin
        win_dma = 1'b1;
        win_idx = IDX_W'(k);
      end
    end
    cpu_win = bus.cpu_cyc_i && (!win_dma || fair_q);
  end

  // Select the registered owner's request signals
  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_ios = 1'b0;
    o_sel = '0;
    o_adr = '0;
    o_dat = '0;
    if (own_cpu_q) begin
      o_cyc = bus.cpu_cyc_i;
      o_stb = bus.cpu_stb_i;
      o_we  = bus.cpu_we_i;
      o_ios = bus.cpu_ios_i;
      o_sel = bus.cpu_sel_i;
      o_adr = bus.cpu_adr_i;
      o_dat = bus.cpu_dat_i;
    end else begin
      for (int unsigned k = 0; k < NDMA; k++) begin
        if (own_idx_q == IDX_W'(k)) begin
          o_cyc = bus.dma_cyc_i[k];
          o_stb = bus.dma_stb_i[k];
          o_we  = bus.dma_we_i[k];
          o_sel = bus.dma_sel_i[2*k +: 2];
          o_adr = bus.dma_adr_i[22*k +: 22];
          o_dat = bus.dma_dat_i[16*k +: 16];
        end
      end
    end
  end

  // Drive slave side, grants, acks and timeout error from the registered owner
  always_comb begin
    granted = (state_q == S_GRANT);
    dma_own = granted && !own_cpu_q;
    tmo_hit = dma_own && o_stb && !blk_q && (tmo_q == TMO_LAST);
    // A timed-out or blocked strobe never reaches the slaves, which also
    // suppresses any late ack in the error cycle.
    stb_eff = granted && o_stb && !blk_q && !tmo_hit;
    // The abandoned cycle under reset gets neither ack nor error.
    ack     = bus.wbs_ack_i && stb_eff && !vm_dclo;

    bus.wbs_cyc_o = granted && o_cyc;
    bus.wbs_stb_o = stb_eff;
    bus.wbs_we_o  = granted && o_we;
    bus.wbs_ios_o = granted && o_ios;
    bus.wbs_sel_o = granted ? o_sel : '0;
    bus.wbs_adr_o = granted ? o_adr : '0;
    bus.wbs_dat_o = granted ? o_dat : '0;
    bus.mst_dat_o = bus.wbs_dat_i;

    bus.cpu_gnt_o = granted && own_cpu_q;
    bus.cpu_ack_o = ack && own_cpu_q;

    bus.dma_gnt_o = '0;
    bus.dma_ack_o = '0;
    bus.dma_err_o = '0;
    for (int unsigned k = 0; k < NDMA; k++) begin
      if (own_idx_q == IDX_W'(k)) begin
        bus.dma_gnt_o[k] = dma_own;
        bus.dma_ack_o[k] = dma_own && ack;
        bus.dma_err_o[k] = tmo_hit && !vm_dclo;
      end
    end
  end

  // Next state: arbitration, tenure tracking, fairness flag and stall timer
  always_comb begin
    state_d   = state_q;
    own_cpu_d = own_cpu_q;
    own_idx_d = own_idx_q;
    fair_d    = fair_q;
    tmo_d     = '0;
    blk_d     = 1'b0;
    case (state_q)
      // TURN arbitrates on its way out exactly as IDLE would, so a pending
      // request is granted two cycles after the previous owner released.
      S_IDLE, S_TURN: begin
        state_d = S_IDLE;
        if (cpu_win) begin
          state_d   = S_GRANT;
          own_cpu_d = 1'b1;
          fair_d    = 1'b0;
        end else if (win_dma) begin
          state_d   = S_GRANT;
          own_cpu_d = 1'b0;
          own_idx_d = win_idx;
          if (CPU_FR != 0 && bus.cpu_cyc_i) fair_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (!o_cyc) begin
          state_d = S_TURN;
          if (CPU_FR != 0 && !own_cpu_q && bus.cpu_cyc_i) fair_d = 1'b1;
        end else if (!own_cpu_q) begin
          blk_d = (blk_q || tmo_hit) && o_stb;
          tmo_d = (stb_eff && !bus.wbs_ack_i) ? tmo_q + 1'b1 : '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and owner registers with synchronous reset
  always_ff @(posedge vm_clk_p) begin
    if (vm_dclo) begin
      state_q   <= S_IDLE;
      own_cpu_q <= 1'b0;
      own_idx_q <= '0;
      tmo_q     <= '0;
      fair_q    <= 1'b0;
      blk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_cpu_q <= own_cpu_d;
      own_idx_q <= own_idx_d;
      tmo_q     <= tmo_d;
      fair_q    <= fair_d;
      blk_q     <= blk_d;
    end
  end

endmodule

// File: tb/tb_wbm_arb.sv
// Scenario bench for wbm_arb with NDMA=2, TMO_W=6, CPU_FR=1.
module tb_wbm_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wbm_arb_if #(.NDMA(2)) bus ();

  wbm_arb #(.NDMA(2), .TMO_W(6), .CPU_FR(1)) dut (
    .vm_clk_p (clk),
    .vm_dclo  (rst),
    .bus      (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] e;

  localparam logic [21:0] CPU_ADR = 22'o177560;
  localparam logic [21:0] CPU_AD2 = 22'o177570;
  localparam logic [21:0] A0      = 22'h012345;
  localparam logic [21:0] A1      = 22'h02AAAA;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0; bus.cpu_we_i = 1'b0;
    bus.cpu_ios_i = 1'b0; bus.cpu_sel_i = '0; bus.cpu_adr_i = '0; bus.cpu_dat_i = '0;
    bus.dma_cyc_i = '0; bus.dma_stb_i = '0; bus.dma_we_i = '0;
    bus.dma_sel_i = '0; bus.dma_adr_i = '0; bus.dma_dat_i = '0;
    bus.wbs_dat_i = '0; bus.wbs_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    nxt(); nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_gnt: got %b expected 0", bus.cpu_gnt_o); end
    n_cmp++; if (bus.dma_gnt_o !== 2'b00) begin n_bad++; $display("FAIL reset_dma_gnt: got %b expected 00", bus.dma_gnt_o); end
    n_cmp++; if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_ios_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_wbs_ctl: got %b expected 0000", {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_ios_o}); end
    n_cmp++; if (bus.wbs_sel_o !== 2'b00) begin n_bad++; $display("FAIL reset_sel: got %b expected 00", bus.wbs_sel_o); end
    n_cmp++; if (bus.dma_err_o !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b expected 00", bus.dma_err_o); end
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_cpu_basic();
    bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_ios_i = 1'b1;
    bus.cpu_sel_i = 2'b11; bus.cpu_adr_i = CPU_ADR; bus.cpu_dat_i = 16'hBEEF;
    sb_q.push_back({10'd0, CPU_ADR});
    sb_q.push_back(32'h0000_BEEF);
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL cpu_gnt_latency: got %b expected 0", bus.cpu_gnt_o); end
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL cpu_gnt: got %b expected 1", bus.cpu_gnt_o); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL cpu_adr: got %o expected %o", bus.wbs_adr_o, e[21:0]); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_dat_o !== e[15:0]) begin n_bad++; $display("FAIL cpu_wdat: got %h expected %h", bus.wbs_dat_o, e[15:0]); end
    n_cmp++; if ({bus.wbs_ios_o, bus.wbs_we_o, bus.wbs_stb_o} !== 3'b111) begin
      n_bad++; $display("FAIL cpu_ios_we_stb: got %b expected 111", {bus.wbs_ios_o, bus.wbs_we_o, bus.wbs_stb_o}); end
    bus.wbs_ack_i = 1'b1; bus.wbs_dat_i = 16'h5A5A;
    sb_q.push_back(32'h0000_5A5A);
    #1;
    n_cmp++; if (bus.cpu_ack_o !== 1'b1) begin n_bad++; $display("FAIL cpu_ack: got %b expected 1", bus.cpu_ack_o); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.mst_dat_o !== e[15:0]) begin n_bad++; $display("FAIL cpu_rdat: got %h expected %h", bus.mst_dat_o, e[15:0]); end
    nxt();
    bus.wbs_ack_i = 1'b0; bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL cpu_release_cyc: got %b expected 0", bus.wbs_cyc_o); end
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL cpu_turn_gnt: got %b expected 0", bus.cpu_gnt_o); end
    nxt();
  endtask

  task automatic test_fair();
    bus.dma_cyc_i = 2'b01; bus.dma_stb_i = 2'b01; bus.dma_adr_i[21:0] = A0;
    bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1; bus.cpu_adr_i = CPU_AD2; bus.cpu_ios_i = 1'b0;
    sb_q.push_back({10'd0, A0});
    nxt();
    @(negedge clk);
    n_cmp++; if ({bus.dma_gnt_o, bus.cpu_gnt_o} !== 3'b010) begin
      n_bad++; $display("FAIL fair_first_gnt: got %b expected 010", {bus.dma_gnt_o, bus.cpu_gnt_o}); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL fair_dma0_adr: got %h expected %h", bus.wbs_adr_o, e[21:0]); end
    bus.wbs_ack_i = 1'b1;
    #1;
    n_cmp++; if ({bus.dma_ack_o, bus.cpu_ack_o} !== 3'b010) begin
      n_bad++; $display("FAIL ungranted_cpu_ack: got %b expected 010", {bus.dma_ack_o, bus.cpu_ack_o}); end
    nxt();
    bus.wbs_ack_i = 1'b0; bus.dma_cyc_i = 2'b00; bus.dma_stb_i = 2'b00;
    @(negedge clk);
    n_cmp++; if (bus.dma_gnt_o !== 2'b01) begin n_bad++; $display("FAIL release_hold_gnt: got %b expected 01", bus.dma_gnt_o); end
    nxt();
    bus.dma_cyc_i = 2'b10; bus.dma_stb_i = 2'b10; bus.dma_adr_i[43:22] = A1;
    sb_q.push_back({10'd0, CPU_AD2});
    @(negedge clk);
    n_cmp++; if ({bus.dma_gnt_o, bus.cpu_gnt_o, bus.wbs_cyc_o} !== 4'b0000) begin
      n_bad++; $display("FAIL fair_turn: got %b expected 0000", {bus.dma_gnt_o, bus.cpu_gnt_o, bus.wbs_cyc_o}); end
    nxt();
    @(negedge clk);
    n_cmp++; if ({bus.dma_gnt_o, bus.cpu_gnt_o} !== 3'b001) begin
      n_bad++; $display("FAIL fair_cpu_gnt: got %b expected 001", {bus.dma_gnt_o, bus.cpu_gnt_o}); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL fair_cpu_adr: got %o expected %o", bus.wbs_adr_o, e[21:0]); end
    nxt();
    bus.cpu_cyc_i = 1'b0; bus.cpu_stb_i = 1'b0;
    sb_q.push_back({10'd0, A1});
    nxt(); nxt();
    @(negedge clk);
    n_cmp++; if ({bus.dma_gnt_o, bus.cpu_gnt_o} !== 3'b100) begin
      n_bad++; $display("FAIL after_cpu_dma1_gnt: got %b expected 100", {bus.dma_gnt_o, bus.cpu_gnt_o}); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL dma1_adr: got %h expected %h", bus.wbs_adr_o, e[21:0]); end
    nxt();
    idle_all();
    nxt(); nxt(); nxt();
  endtask

  task automatic test_back_to_back();
    bus.dma_cyc_i = 2'b11; bus.dma_stb_i = 2'b11; bus.dma_we_i = 2'b11;
    bus.dma_adr_i = {22'h000200, 22'h000100}; bus.dma_dat_i = {16'h2222, 16'h1111};
    sb_q.push_back(32'h0000_0100); sb_q.push_back(32'h0000_1111);
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.dma_gnt_o !== 2'b01) begin n_bad++; $display("FAIL b2b_first: got %b expected 01", bus.dma_gnt_o); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL b2b_adr0: got %h expected %h", bus.wbs_adr_o, e[21:0]); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_dat_o !== e[15:0]) begin n_bad++; $display("FAIL b2b_dat0: got %h expected %h", bus.wbs_dat_o, e[15:0]); end
    nxt();
    bus.dma_cyc_i = 2'b10; bus.dma_stb_i = 2'b10;
    @(negedge clk);
    n_cmp++; if (bus.wbs_cyc_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drop_cyc: got %b expected 0", bus.wbs_cyc_o); end
    nxt();
    sb_q.push_back(32'h0000_0200); sb_q.push_back(32'h0000_2222);
    @(negedge clk);
    n_cmp++; if ({bus.dma_gnt_o, bus.wbs_cyc_o, bus.wbs_stb_o} !== 4'b0000) begin
      n_bad++; $display("FAIL b2b_turn: got %b expected 0000", {bus.dma_gnt_o, bus.wbs_cyc_o, bus.wbs_stb_o}); end
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.dma_gnt_o !== 2'b10) begin n_bad++; $display("FAIL b2b_second: got %b expected 10", bus.dma_gnt_o); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_adr_o !== e[21:0]) begin n_bad++; $display("FAIL b2b_adr1: got %h expected %h", bus.wbs_adr_o, e[21:0]); end
    e = sb_q.pop_front();
    n_cmp++; if (bus.wbs_dat_o !== e[15:0]) begin n_bad++; $display("FAIL b2b_dat1: got %h expected %h", bus.wbs_dat_o, e[15:0]); end
    nxt();
    idle_all();
    nxt(); nxt(); nxt();
  endtask

  task automatic test_timeout();
    bus.dma_cyc_i = 2'b10; bus.dma_stb_i = 2'b10;
    nxt();
    bus.cpu_cyc_i = 1'b1; bus.cpu_stb_i = 1'b1;
    for (int i = 2; i <= 62; i++) nxt();
    sb_q.push_back(32'h0000_0002);
    @(negedge clk);
    n_cmp++; if ({bus.dma_err_o, bus.wbs_stb_o, bus.cpu_gnt_o} !== 4'b0010) begin
      n_bad++; $display("FAIL tmo_cycle62: got %b expected 0010", {bus.dma_err_o, bus.wbs_stb_o, bus.cpu_gnt_o}); end
    nxt();
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++; if (bus.dma_err_o !== e[1:0]) begin n_bad++; $display("FAIL tmo_err: got %b expected %b", bus.dma_err_o, e[1:0]); end
    n_cmp++; if (bus.wbs_stb_o !== 1'b0) begin n_bad++; $display("FAIL tmo_stb_err_cycle: got %b expected 0", bus.wbs_stb_o); end
    bus.wbs_ack_i = 1'b1;
    #1;
    n_cmp++; if (bus.dma_ack_o !== 2'b00) begin n_bad++; $display("FAIL tmo_late_ack: got %b expected 00", bus.dma_ack_o); end
    nxt();
    bus.wbs_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.dma_err_o, bus.wbs_stb_o, bus.dma_gnt_o} !== 5'b00010) begin
      n_bad++; $display("FAIL tmo_after: got %b expected 00010", {bus.dma_err_o, bus.wbs_stb_o, bus.dma_gnt_o}); end
    nxt();
    bus.dma_cyc_i = 2'b00; bus.dma_stb_i = 2'b00;
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL tmo_turn_cpu: got %b expected 0", bus.cpu_gnt_o); end
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL tmo_cpu_gnt: got %b expected 1", bus.cpu_gnt_o); end
  endtask

  task automatic test_reset_mid();
    // CPU is the owner on entry
    bus.wbs_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.cpu_gnt_o, bus.cpu_ack_o} !== 2'b10) begin
      n_bad++; $display("FAIL rst_mid_ack: got %b expected 10", {bus.cpu_gnt_o, bus.cpu_ack_o}); end
    nxt();
    bus.wbs_ack_i = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.cpu_gnt_o, bus.dma_gnt_o, bus.wbs_cyc_o} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_mid_drop: got %b expected 0000", {bus.cpu_gnt_o, bus.dma_gnt_o, bus.wbs_cyc_o}); end
    nxt();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b expected 0", bus.cpu_gnt_o); end
    nxt();
    @(negedge clk);
    n_cmp++; if (bus.cpu_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rst_regrant: got %b expected 1", bus.cpu_gnt_o); end
    nxt();
    idle_all();
    nxt(); nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_cpu_basic();
    test_fair();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
